tcp_csum_fix: RTL

TCP_CSUM_FIX -- requirements
Module: tcp_csum_fix

---
 rtl/nat_pkg.sv | 36 +++
 rtl/pkt_buf.sv | 24 ++
 rtl/tcp_csum_fix.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/nat_pkg.sv
// Shared packet offsets and constants for the NAT and checksum stages.
// Byte offsets count from the first Ethernet byte (no VLAN tag).
package nat_pkg;

  localparam int ETH_TYPE_OFF   = 12;
  localparam int IP_VER_IHL_OFF = 14;
  localparam int IP_LEN_OFF     = 16;
  localparam int IP_PROTO_OFF   = 23;
  localparam int IP_SRC_OFF     = 26;
  localparam int IP_DST_OFF     = 30;
  localparam int TCP_OFF        = 34;
  localparam int TCP_CSUM_OFF   = 50;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_TCP  = 8'h06;
  localparam logic [3:0]  IP_IHL_NOOPT  = 4'd5;
  // IPv4 header + TCP header without options
  localparam logic [15:0] TCP_MIN_LEN   = 16'd40;

  localparam int CSUM_BEAT = TCP_CSUM_OFF / 8;
  localparam int CSUM_LSB  = (TCP_CSUM_OFF % 8) * 8;

  typedef enum logic [1:0] {
    ST_RX,
    ST_FOLD,
    ST_TX
  } csum_st_e;

  function automatic logic [7:0] lane_byte(
    input logic [63:0] d,
    input int          off
  );
    return d[8*(off%8) +: 8];
  endfunction

endpackage

// File: rtl/pkt_buf.sv
// Simple dual-port packet RAM, one write and one registered read port.
// Ports: clk, we_i/waddr_i/wdata_i write, re_i/raddr_i read, rdata_o.
module pkt_buf #(
  parameter int DEPTH = 256,
  parameter int W     = 73,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/tcp_csum_fix.sv
// Store-and-forward TCP checksum recompute after NAT rewrite.
// Ports: s_axis_* packet in, m_axis_* packet out, drop_cnt oversize drops.
module tcp_csum_fix
  import nat_pkg::*;
#(
  parameter int BUF_BEATS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] drop_cnt
);

  localparam int AW = (BUF_BEATS > 1) ? $clog2(BUF_BEATS) : 1;
  localparam int CW = $clog2(BUF_BEATS + 1);

  csum_st_e      state_q, state_d;
  logic          fold_q, fold_d;
  logic          rdy_q, rdy_d;
  logic          vld_q, vld_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [AW-1:0] oidx_q, oidx_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   drop_q, drop_d;
  logic [15:0]   tl_q, tl_d;
  logic          eth_q, eth_d;
  logic          ihl_q, ihl_d;
  logic          tcp_q, tcp_d;

  logic          accept;
  logic          full;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [72:0]   rd_data;
  logic [31:0]   wsum;
  logic [31:0]   acc_base;
  logic [15:0]   tl_in;
  logic [15:0]   csum;
  logic [7:0]    ihl_b;
  logic          elig;
  logic          csum_beat;

  assign accept = s_axis_tvalid & rdy_q;
  // beat_q saturates here: the next beat is one past the buffer
  assign full = (beat_q == CW'(BUF_BEATS));
  assign tl_in = {lane_byte(s_axis_tdata, IP_LEN_OFF),
                  lane_byte(s_axis_tdata, IP_LEN_OFF + 1)};
  assign ihl_b = lane_byte(s_axis_tdata, IP_VER_IHL_OFF);
  assign acc_base = (beat_q == '0) ? '0 : acc_q;

  // Pseudo-header IPs and TCP bytes form one contiguous range
  // starting at the source IP; the stale checksum is masked out.
  always_comb begin
    logic [16:0] bidx;
    logic [16:0] pend;
    logic [7:0]  mb [8];
    pend = {1'b0, tl_q} + 17'd14;
    for (int i = 0; i < 8; i++) begin
      bidx  = 17'({beat_q, 3'(i)});
      mb[i] = '0;
      if (s_axis_tkeep[i] &&
          bidx >= 17'(IP_SRC_OFF) &&
          bidx < pend &&
          bidx != 17'(TCP_CSUM_OFF) &&
          bidx != 17'(TCP_CSUM_OFF + 1))
        mb[i] = s_axis_tdata[8*i +: 8];
    end
    wsum = '0;
    for (int j = 0; j < 4; j++)
      wsum = wsum + {16'h0, mb[2*j], mb[2*j+1]};
    // length beat carries no summed bytes, so its slots take
    // the pseudo-header protocol and TCP length words
    if (beat_q == CW'(IP_LEN_OFF / 8))
      wsum = wsum + {24'h0, IP_PROTO_TCP}
                  + {16'h0, tl_in - 16'd20};
  end

  always_comb begin
    state_d = state_q;
    fold_d  = fold_q;
    rdy_d   = rdy_q;
    vld_d   = vld_q;
    beat_d  = beat_q;
    oidx_d  = oidx_q;
    acc_d   = acc_q;
    drop_d  = drop_q;
    tl_d    = tl_q;
    eth_d   = eth_q;
    ihl_d   = ihl_q;
    tcp_d   = tcp_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    rd_addr = oidx_q + AW'(1);
    unique case (state_q)
      ST_RX: begin
        if (accept) begin
          wr_en = !full;
          if (!full) beat_d = beat_q + CW'(1);
          acc_d = acc_base + wsum;
          if (beat_q == '0) begin
            eth_d = 1'b0;
            ihl_d = 1'b0;
            tcp_d = 1'b0;
          end
          if (beat_q == CW'(ETH_TYPE_OFF / 8))
            eth_d = {lane_byte(s_axis_tdata, ETH_TYPE_OFF),
                     lane_byte(s_axis_tdata, ETH_TYPE_OFF + 1)}
                    == ETH_TYPE_IPV4;
          if (beat_q == CW'(IP_VER_IHL_OFF / 8))
            ihl_d = (ihl_b[3:0] == IP_IHL_NOOPT);
          if (beat_q == CW'(IP_LEN_OFF / 8))
            tl_d = tl_in;
          if (beat_q == CW'(IP_PROTO_OFF / 8))
            tcp_d = lane_byte(s_axis_tdata, IP_PROTO_OFF)
                    == IP_PROTO_TCP;
          if (s_axis_tlast) begin
            beat_d = '0;
            if (full) begin
              drop_d = drop_q + 32'd1;
            end else begin
              state_d = ST_FOLD;
              fold_d  = 1'b0;
              rdy_d   = 1'b0;
            end
          end
        end
      end
      ST_FOLD: begin
        acc_d  = {16'h0, acc_q[15:0]} + {16'h0, acc_q[31:16]};
        fold_d = 1'b1;
        if (fold_q) begin
          state_d = ST_TX;
          rd_en   = 1'b1;
          rd_addr = '0;
          oidx_d  = '0;
          vld_d   = 1'b1;
        end
      end
      ST_TX: begin
        if (m_axis_tready) begin
          if (rd_data[72]) begin
            state_d = ST_RX;
            vld_d   = 1'b0;
            rdy_d   = 1'b1;
          end else begin
            rd_en  = 1'b1;
            oidx_d = oidx_q + AW'(1);
          end
        end
      end
      default: state_d = ST_RX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RX;
      fold_q  <= 1'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      beat_q  <= '0;
      oidx_q  <= '0;
      acc_q   <= '0;
      drop_q  <= '0;
      tl_q    <= '0;
      eth_q   <= 1'b0;
      ihl_q   <= 1'b0;
      tcp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fold_q  <= fold_d;
      rdy_q   <= (state_d == ST_RX) ? 1'b1 : rdy_d;
      vld_q   <= vld_d;
      beat_q  <= beat_d;
      oidx_q  <= oidx_d;
      acc_q   <= acc_d;
      drop_q  <= drop_d;
      tl_q    <= tl_d;
      eth_q   <= eth_d;
      ihl_q   <= ihl_d;
      tcp_q   <= tcp_d;
    end
  end

  pkt_buf #(
    .DEPTH (BUF_BEATS),
    .W     (73),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (beat_q[AW-1:0]),
    .wdata_i ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign elig = eth_q & ihl_q & tcp_q & (tl_q >= TCP_MIN_LEN);
  assign csum_beat = (32'(oidx_q) == 32'(CSUM_BEAT));
  assign csum = ~acc_q[15:0];

  // RAM output register holds while stalled; gating keeps
  // the idle bus at zero without resetting the RAM
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    m_axis_tlast = 1'b0;
    if (vld_q) begin
      {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = rd_data;
      if (elig && csum_beat)
        m_axis_tdata[CSUM_LSB +: 16] = {csum[7:0], csum[15:8]};
    end
  end

  assign m_axis_tvalid = vld_q;
  assign s_axis_tready = rdy_q;
  assign drop_cnt      = drop_q;

endmodule
